// File: rtl/clock_timekeeper.sv
// Time-of-day counter (HH:MM:SS, 24 h).
// Run mode: advances once per second from an internal prescaler.
// Setting mode: time is frozen, seconds cleared on entry, and the inc button
// (synchronised, edge-detected, with press-and-hold auto-repeat) bumps the
// selected hours or minutes field.
module clock_timekeeper #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setting,
  input  logic       setting_h,
  input  logic       setting_m,
  input  logic       inc_n,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_pulse
);

  localparam int PRE_W   = $clog2(TICK_DIV);
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] PER_LOAD = CNT_W'(REPEAT_PER);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1, sync2, prev;
  logic             setting_d;
  logic [1:0]       sel_d;
  logic [PRE_W-1:0] prescaler_reg, prescaler_next;
  logic [CNT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic [4:0]       hours_reg, hours_next;
  logic [5:0]       minutes_reg, minutes_next;
  logic [5:0]       seconds_reg, seconds_next;
  logic             sec_pulse_reg;

  logic qualified, sel_change, press, hold_ok, start, do_inc, tick;

  // Request is valid only in setting mode with exactly one field selected.
  assign qualified  = setting & (setting_h ^ setting_m);
  assign sel_change = ({setting_h, setting_m} != sel_d);
  assign press      = ~sync2 & prev;
  // A change of field select while held counts as a disqualifying cycle.
  assign hold_ok    = qualified & ~sync2 & ~sel_change;
  // Counter at zero means "no hold in progress": a held, re-qualified button
  // restarts the schedule exactly like a fresh press.
  assign start      = press | (rpt_cnt_reg == '0);
  assign do_inc     = hold_ok & (start | (rpt_cnt_reg == CNT_ONE));
  assign tick       = ~setting & (prescaler_reg == PRE_LAST);

  // Auto-repeat countdown: load REPEAT_DLY on the first increment, then
  // REPEAT_PER after each repeat; increment fires when it reaches one.
  always_comb begin
    rpt_cnt_next = rpt_cnt_reg;
    if (!hold_ok)
      rpt_cnt_next = '0;
    else if (start)
      rpt_cnt_next = DLY_LOAD;
    else if (rpt_cnt_reg == CNT_ONE)
      rpt_cnt_next = PER_LOAD;
    else
      rpt_cnt_next = rpt_cnt_reg - CNT_ONE;
  end

  // Prescaler only counts in run mode; held at zero while setting.
  always_comb begin
    prescaler_next = prescaler_reg + PRE_W'(1);
    if (setting || tick)
      prescaler_next = '0;
  end

  // Field updates: setting mode has priority over the run-mode tick.
  always_comb begin
    hours_next   = hours_reg;
    minutes_next = minutes_reg;
    seconds_next = seconds_reg;
    if (setting) begin
      if (!setting_d)
        seconds_next = '0;
      if (do_inc && setting_h)
        hours_next = (hours_reg == 5'd23) ? 5'd0 : hours_reg + 5'd1;
      else if (do_inc)
        minutes_next = (minutes_reg == 6'd59) ? 6'd0 : minutes_reg + 6'd1;
    end else if (tick) begin
      if (seconds_reg == 6'd59) begin
        seconds_next = '0;
        if (minutes_reg == 6'd59) begin
          minutes_next = '0;
          hours_next   = (hours_reg == 5'd23) ? 5'd0 : hours_reg + 5'd1;
        end else begin
          minutes_next = minutes_reg + 6'd1;
        end
      end else begin
        seconds_next = seconds_reg + 6'd1;
      end
    end
  end

  // State registers; button flops reset to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      prev          <= 1'b1;
      setting_d     <= 1'b0;
      sel_d         <= 2'b00;
      prescaler_reg <= '0;
      rpt_cnt_reg   <= '0;
      hours_reg     <= '0;
      minutes_reg   <= '0;
      seconds_reg   <= '0;
      sec_pulse_reg <= 1'b0;
    end else begin
      sync1         <= inc_n;
      sync2         <= sync1;
      prev          <= sync2;
      setting_d     <= setting;
      sel_d         <= {setting_h, setting_m};
      prescaler_reg <= prescaler_next;
      rpt_cnt_reg   <= rpt_cnt_next;
      hours_reg     <= hours_next;
      minutes_reg   <= minutes_next;
      seconds_reg   <= seconds_next;
      sec_pulse_reg <= tick;
    end
  end

  assign hours     = hours_reg;
  assign minutes   = minutes_reg;
  assign seconds   = seconds_reg;
  assign sec_pulse = sec_pulse_reg;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Self-checking bench for clock_timekeeper: directed scenarios plus a random
// phase, every cycle compared against a seconds-of-day reference model.
module tb_clock_timekeeper;

  localparam int TICK_DIV   = 4;
  localparam int REPEAT_DLY = 8;
  localparam int REPEAT_PER = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       setting, setting_h, setting_m, inc_n;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       sec_pulse;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_h, m_m, m_s, m_pulse;
  int run_n;      // run-mode edges since last setting/reset
  int hold_k;     // consecutive qualified edges with the button seen low
  int set_d;
  int in0, in1;   // inc_n sampled one and two edges ago

  clock_timekeeper #(
    .TICK_DIV  (TICK_DIV),
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .setting  (setting),
    .setting_h(setting_h),
    .setting_m(setting_m),
    .inc_n    (inc_n),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_pulse = 0;
    run_n = 0; hold_k = 0; set_d = 0; in0 = 1; in1 = 1;
  endtask

  // One clock edge of the reference, using the inputs about to be sampled.
  task automatic model_edge();
    bit qual, fire;
    int tod;
    qual    = setting && (setting_h != setting_m);
    m_pulse = 0;
    if (setting) begin
      run_n = 0;
      if (set_d == 0) m_s = 0;
      if (qual && in1 == 0) begin
        fire = (hold_k == 0) || (hold_k == REPEAT_DLY) ||
               (hold_k > REPEAT_DLY && ((hold_k - REPEAT_DLY) % REPEAT_PER) == 0);
        if (fire) begin
          if (setting_h) m_h = (m_h + 1) % 24;
          else           m_m = (m_m + 1) % 60;
        end
        hold_k++;
      end else begin
        hold_k = 0;
      end
    end else begin
      hold_k = 0;
      if ((run_n % TICK_DIV) == TICK_DIV - 1) begin
        tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h = tod / 3600;
        m_m = (tod / 60) % 60;
        m_s = tod % 60;
        m_pulse = 1;
      end
      run_n++;
    end
    set_d = setting;
    in1   = in0;
    in0   = inc_n;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("hours", hours, m_h);
    check("minutes", minutes, m_m);
    check("seconds", seconds, m_s);
    check("sec_pulse", sec_pulse, m_pulse);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold the button low for n edges, then release and let the synchroniser drain.
  task automatic hold_button(input int n);
    inc_n = 1'b0;
    steps(n);
    inc_n = 1'b1;
    steps(3);
  endtask

  // Run until n sec_pulses observed, with a cycle budget.
  task automatic run_ticks(input int n);
    int seen = 0;
    int budget = n * TICK_DIV + TICK_DIV;
    while (seen < n && budget > 0) begin
      step();
      if (sec_pulse === 1'b1) seen++;
      budget--;
    end
    if (seen < n) check("tick_timeout", seen, n);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; setting = 1'b0; setting_h = 1'b0; setting_m = 1'b0; inc_n = 1'b1;
    #2;
    check("rst_hours", hours, 0);
    check("rst_minutes", minutes, 0);
    check("rst_seconds", seconds, 0);
    check("rst_pulse", sec_pulse, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // 1: async reset mid-count, right after a tick
    steps(4);
    check("pre_rst_seconds", seconds, 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_seconds", seconds, 0);
    check("async_rst_pulse", sec_pulse, 0);
    check("async_rst_hours", hours, 0);
    #1;
    rst = 1'b0;
    model_reset();
    $display("scenario 1: async reset mid-count");

    // 2: set 23:59, run through midnight
    setting = 1'b1; setting_m = 1'b1; setting_h = 1'b0;
    hold_button(180);
    check("set_minutes_59", minutes, 59);
    setting_m = 1'b0; setting_h = 1'b1;
    hold_button(72);
    check("set_hours_23", hours, 23);
    setting = 1'b0; setting_h = 1'b0;
    run_ticks(59);
    check("t59_h", hours, 23);
    check("t59_m", minutes, 59);
    check("t59_s", seconds, 59);
    run_ticks(1);
    check("t60_h", hours, 0);
    check("t60_m", minutes, 0);
    check("t60_s", seconds, 0);
    check("t60_pulse", sec_pulse, 1);
    run_ticks(1);
    check("t61_s", seconds, 1);
    $display("scenario 2: midnight rollover");

    // 3: minutes 59 -> 0 with no carry, two-edge latency
    setting = 1'b1; setting_m = 1'b1;
    hold_button(180);
    check("min59_again", minutes, 59);
    inc_n = 1'b0;
    step();
    step();
    inc_n = 1'b1;
    check("lat_n1_minutes", minutes, 59);
    step();
    check("lat_n2_minutes", minutes, 0);
    check("lat_n2_hours", hours, 0);
    check("lat_n2_seconds", seconds, 0);
    steps(2);
    $display("scenario 3: minute wrap without carry");

    // 4: auto-repeat on hours, 20 held cycles
    setting_m = 1'b0; setting_h = 1'b1;
    steps(2);
    hold_button(20);
    check("repeat_hours", hours, 5);
    $display("scenario 4: auto-repeat");

    // 5: button activity in run mode is ignored
    setting = 1'b0; setting_h = 1'b0;
    for (int i = 0; i < 10; i++) begin
      inc_n = ~inc_n;
      step();
    end
    inc_n = 1'b1;
    steps(3);
    check("run_btn_hours", hours, 5);
    check("run_btn_minutes", minutes, 0);
    $display("scenario 5: run-mode button ignored");

    // 6: both fields selected -> no change; then first tick after leaving
    setting = 1'b1; setting_h = 1'b1; setting_m = 1'b1;
    steps(2);
    hold_button(4);
    check("both_sel_hours", hours, 5);
    check("both_sel_minutes", minutes, 0);
    setting = 1'b0; setting_h = 1'b0; setting_m = 1'b0;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (sec_pulse !== 1'b1 && cnt < 8);
    check("first_pulse_delay", cnt, 4);
    check("first_pulse_seconds", seconds, 1);
    $display("scenario 6: invalid select, first tick delay");

    // random phase
    for (int seg = 0; seg < 20; seg++) begin
      int len = $urandom_range(5, 40);
      if ($urandom_range(0, 2) == 0) begin
        setting = 1'b0; setting_h = 1'b0; setting_m = 1'b0;
      end else begin
        setting = 1'b1;
        setting_h = 1'($urandom_range(0, 1));
        setting_m = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 5) == 0) inc_n = ~inc_n;
        step();
      end
      inc_n = 1'b1;
      steps(3);
      $display("random segment %0d: setting=%0b h=%0b m=%0b len=%0d", seg, setting, setting_h, setting_m, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
